// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - per-frame sprite layer sequencer for the pet datapath
module frame_draw_scheduler #(
  parameter logic [5:0]  OBJ_FRAMES     = 6'd30,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       draw_done,
  input  logic       start_btn,
  input  logic       deceased,
  input  logic       dying,
  input  logic       sick,
  input  logic       hungry,
  input  logic       dirty,
  input  logic       bored,
  input  logic       sleeping,
  input  logic       foodGiven,
  input  logic       ballGiven,
  input  logic       broomGiven,
  input  logic       pillsGiven,
  input  logic       firstAidGiven,
  output logic       draw_bg,
  output logic       draw_start,
  output logic       draw_end,
  output logic       draw_pet,
  output logic       draw_zs,
  output logic       draw_food,
  output logic       draw_ball,
  output logic       draw_broom,
  output logic       draw_pills,
  output logic       draw_firstAid,
  output logic       draw_hunger,
  output logic       draw_bored,
  output logic       draw_dirty,
  output logic       draw_sick,
  output logic       draw_dying,
  output logic       frame_busy,
  output logic [7:0] overrun_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {M_START, M_PLAY, M_END} mode_t;
  typedef enum logic [1:0] {F_WAIT, F_NEXT, F_DRAW} frame_t;

  // Item codes held in the latch
  localparam logic [2:0] I_FOOD = 3'd0, I_BALL = 3'd1, I_BROOM = 3'd2,
                         I_PILLS = 3'd3, I_FIRSTAID = 3'd4;
  // Bubble codes; B_NONE means no status bubble this frame
  localparam logic [2:0] B_NONE = 3'd0, B_DYING = 3'd1, B_SICK = 3'd2,
                         B_HUNGRY = 3'd3, B_DIRTY = 3'd4, B_BORED = 3'd5;

  mode_t       mode_q, mode_n;
  frame_t      state_q, state_n;
  logic [2:0]  idx_q, idx_n;
  logic        start_frame, frame_end;
  logic [2:0]  layer_cnt;
  logic        layer_en;
  logic        tmo_hit;
  logic [19:0] tmo_cnt;

  logic [5:0]  obj_frames;
  logic [2:0]  item_sel;
  logic        any_given;
  logic [2:0]  given_sel;
  logic [2:0]  bubble_sel;

  logic        snap_sleep;
  logic        snap_item;
  logic [2:0]  snap_item_sel;
  logic [2:0]  snap_bubble;

  assign any_given  = foodGiven | ballGiven | broomGiven | pillsGiven | firstAidGiven;
  assign layer_cnt  = (mode_q == M_PLAY) ? 3'd5 : 3'd1;
  assign tmo_hit    = (state_q == F_DRAW) && !draw_done && (tmo_cnt == TIMEOUT_CYCLES - 20'd1);
  assign frame_busy = (state_q != F_WAIT);

  // Item priority when several pulses land together
  always_comb begin
    given_sel = I_BALL;
    if (firstAidGiven)   given_sel = I_FIRSTAID;
    else if (pillsGiven) given_sel = I_PILLS;
    else if (foodGiven)  given_sel = I_FOOD;
    else if (broomGiven) given_sel = I_BROOM;
  end

  // Status bubble priority, sampled into the snapshot at frame start
  always_comb begin
    bubble_sel = B_NONE;
    if (dying)       bubble_sel = B_DYING;
    else if (sick)   bubble_sel = B_SICK;
    else if (hungry) bubble_sel = B_HUNGRY;
    else if (dirty)  bubble_sel = B_DIRTY;
    else if (bored)  bubble_sel = B_BORED;
  end

  // Whether the layer at the current index is drawn this frame
  always_comb begin
    layer_en = 1'b0;
    if (mode_q == M_PLAY) begin
      case (idx_q)
        3'd0, 3'd1: layer_en = 1'b1;
        3'd2:       layer_en = snap_sleep;
        3'd3:       layer_en = snap_item;
        3'd4:       layer_en = (snap_bubble != B_NONE);
        default:    layer_en = 1'b0;
      endcase
    end else begin
      layer_en = (idx_q == 3'd0);
    end
  end

  // Frame and mode next-state logic
  always_comb begin
    state_n     = state_q;
    idx_n       = idx_q;
    mode_n      = mode_q;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      F_WAIT: begin
        if (frame_tick) begin
          start_frame = 1'b1;
          idx_n       = 3'd0;
          state_n     = F_NEXT;
          case (mode_q)
            M_START: if (start_btn) mode_n = M_PLAY;
            M_PLAY:  if (deceased)  mode_n = M_END;
            M_END:   if (start_btn) mode_n = M_START;
            default: mode_n = M_START;
          endcase
        end
      end
      F_NEXT: begin
        if (idx_q >= layer_cnt) begin
          state_n   = F_WAIT;
          frame_end = 1'b1;
        end else if (layer_en) begin
          state_n = F_DRAW;
        end else begin
          idx_n = idx_q + 3'd1;
        end
      end
      F_DRAW: begin
        if (draw_done || tmo_hit) begin
          idx_n   = idx_q + 3'd1;
          state_n = F_NEXT;
        end
      end
      default: state_n = F_WAIT;
    endcase
  end

  // State, mode and layer index registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= F_WAIT;
      mode_q  <= M_START;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      idx_q   <= idx_n;
    end
  end

  // Per-frame snapshot so layer choices stay fixed while the frame is drawn
  always_ff @(posedge clk) begin
    if (!resetn) begin
      snap_sleep    <= 1'b0;
      snap_item     <= 1'b0;
      snap_item_sel <= I_FOOD;
      snap_bubble   <= B_NONE;
    end else if (start_frame) begin
      snap_sleep    <= sleeping;
      snap_item     <= (obj_frames != 6'd0);
      snap_item_sel <= item_sel;
      snap_bubble   <= bubble_sel;
    end
  end

  // Item latch: a new pulse beats the end-of-frame decrement; leaving play empties it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      obj_frames <= 6'd0;
      item_sel   <= I_FOOD;
    end else if (mode_q == M_PLAY && mode_n != M_PLAY) begin
      obj_frames <= 6'd0;
      item_sel   <= I_FOOD;
    end else if (mode_q == M_PLAY && any_given) begin
      obj_frames <= OBJ_FRAMES;
      item_sel   <= given_sel;
    end else if (frame_end && mode_q == M_PLAY && obj_frames != 6'd0) begin
      obj_frames <= obj_frames - 6'd1;
    end
  end

  // Layer watchdog: counts draw cycles, restarts on every layer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt     <= 20'd0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == F_DRAW && !draw_done && !tmo_hit) tmo_cnt <= tmo_cnt + 20'd1;
      else                                             tmo_cnt <= 20'd0;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  // Saturating count of ticks that arrive while a frame is still in progress
  always_ff @(posedge clk) begin
    if (!resetn) overrun_cnt <= 8'd0;
    else if (frame_tick && state_q != F_WAIT && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end

  // One-hot layer enable decode, only while a layer is being drawn
  always_comb begin
    draw_bg = 1'b0; draw_start = 1'b0; draw_end = 1'b0; draw_pet = 1'b0; draw_zs = 1'b0;
    draw_food = 1'b0; draw_ball = 1'b0; draw_broom = 1'b0; draw_pills = 1'b0; draw_firstAid = 1'b0;
    draw_hunger = 1'b0; draw_bored = 1'b0; draw_dirty = 1'b0; draw_sick = 1'b0; draw_dying = 1'b0;
    if (state_q == F_DRAW) begin
      case (mode_q)
        M_START: draw_start = 1'b1;
        M_END:   draw_end   = 1'b1;
        M_PLAY: begin
          case (idx_q)
            3'd0: draw_bg  = 1'b1;
            3'd1: draw_pet = 1'b1;
            3'd2: draw_zs  = 1'b1;
            3'd3: begin
              case (snap_item_sel)
                I_FOOD:     draw_food     = 1'b1;
                I_BALL:     draw_ball     = 1'b1;
                I_BROOM:    draw_broom    = 1'b1;
                I_PILLS:    draw_pills    = 1'b1;
                I_FIRSTAID: draw_firstAid = 1'b1;
                default:    draw_food     = 1'b0;
              endcase
            end
            3'd4: begin
              case (snap_bubble)
                B_DYING:  draw_dying  = 1'b1;
                B_SICK:   draw_sick   = 1'b1;
                B_HUNGRY: draw_hunger = 1'b1;
                B_DIRTY:  draw_dirty  = 1'b1;
                B_BORED:  draw_bored  = 1'b1;
                default:  draw_dying  = 1'b0;
              endcase
            end
            default: draw_bg = 1'b0;
          endcase
        end
        default: draw_start = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - directed bench for frame_draw_scheduler
module tb_frame_draw_scheduler;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame_tick = 0, draw_done = 0, start_btn = 0;
  logic deceased = 0, dying = 0, sick = 0, hungry = 0, dirty = 0, bored = 0, sleeping = 0;
  logic foodGiven = 0, ballGiven = 0, broomGiven = 0, pillsGiven = 0, firstAidGiven = 0;
  logic draw_bg, draw_start, draw_end, draw_pet, draw_zs;
  logic draw_food, draw_ball, draw_broom, draw_pills, draw_firstAid;
  logic draw_hunger, draw_bored, draw_dirty, draw_sick, draw_dying;
  logic frame_busy, timeout_err;
  logic [7:0] overrun_cnt;
  logic [14:0] draws;

  int tests = 0;
  int fails = 0;

  localparam logic [14:0] L_BG    = 15'd1 << 14;
  localparam logic [14:0] L_START = 15'd1 << 13;
  localparam logic [14:0] L_END   = 15'd1 << 12;
  localparam logic [14:0] L_PET   = 15'd1 << 11;
  localparam logic [14:0] L_PILLS = 15'd1 << 6;
  localparam logic [14:0] L_SICK  = 15'd1 << 1;

  frame_draw_scheduler #(.OBJ_FRAMES(6'd3), .TIMEOUT_CYCLES(20'd16)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .draw_done(draw_done),
    .start_btn(start_btn), .deceased(deceased), .dying(dying), .sick(sick),
    .hungry(hungry), .dirty(dirty), .bored(bored), .sleeping(sleeping),
    .foodGiven(foodGiven), .ballGiven(ballGiven), .broomGiven(broomGiven),
    .pillsGiven(pillsGiven), .firstAidGiven(firstAidGiven),
    .draw_bg(draw_bg), .draw_start(draw_start), .draw_end(draw_end), .draw_pet(draw_pet),
    .draw_zs(draw_zs), .draw_food(draw_food), .draw_ball(draw_ball), .draw_broom(draw_broom),
    .draw_pills(draw_pills), .draw_firstAid(draw_firstAid), .draw_hunger(draw_hunger),
    .draw_bored(draw_bored), .draw_dirty(draw_dirty), .draw_sick(draw_sick),
    .draw_dying(draw_dying), .frame_busy(frame_busy), .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );

  assign draws = {draw_bg, draw_start, draw_end, draw_pet, draw_zs, draw_food, draw_ball,
                  draw_broom, draw_pills, draw_firstAid, draw_hunger, draw_bored,
                  draw_dirty, draw_sick, draw_dying};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // At most one layer enable may be high at any time
  always @(negedge clk) begin
    if (resetn) check("onehot", {31'd0, $onehot0(draws)}, 32'd1);
  end

  // Wait for a layer, check it, hold it for 'hold' cycles and return done on the last one
  task automatic serve(input string tag, input logic [14:0] exp, input int hold, input int exp_gap);
    int gap = 0;
    int hi = 0;
    while (draws == 15'd0 && gap < 64) begin
      step();
      gap++;
    end
    check({tag, "_gap"}, gap, exp_gap);
    check({tag, "_id"}, {17'd0, draws}, {17'd0, exp});
    for (int k = 0; k < hold; k++) begin
      if (draws == exp) hi++;
      if (k == hold - 1) draw_done = 1'b1;
      step();
      draw_done = 1'b0;
    end
    check({tag, "_len"}, hi, hold);
    check({tag, "_drop"}, {17'd0, draws}, 32'd0);
  endtask

  // Count remaining busy cycles of the frame; no layer may be drawn during them
  task automatic finish_frame(input string tag, input int exp_n);
    int n = 0;
    int bad = 0;
    while (frame_busy && n < 200) begin
      if (draws != 15'd0) bad++;
      step();
      n++;
    end
    check({tag, "_idle"}, n, exp_n);
    check({tag, "_extra"}, bad, 0);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    start_btn = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) step();
    check("rst_draws", {17'd0, draws}, 32'd0);
    check("rst_busy", {31'd0, frame_busy}, 32'd0);
    check("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);
    resetn = 1'b1;
    step();

    // T1: start screen
    tick();
    check("t1_busy", {31'd0, frame_busy}, 32'd1);
    check("t1_pre", {17'd0, draws}, 32'd0);
    serve("t1_start", L_START, 1, 1);
    finish_frame("t1", 1);

    // T2: enter play, bg then pet only
    start_btn = 1'b1;
    tick();
    serve("t2_bg", L_BG, 5, 1);
    serve("t2_pet", L_PET, 5, 1);
    finish_frame("t2", 4);

    // T3: sick outranks hungry; snapshot holds through the frame
    hungry = 1'b1; sick = 1'b1;
    tick();
    serve("t3_bg", L_BG, 2, 1);
    sick = 1'b0;
    serve("t3_pet", L_PET, 2, 1);
    serve("t3_bubble", L_SICK, 2, 3);
    finish_frame("t3", 1);
    hungry = 1'b0;

    // T4: simultaneous pulses, pills wins and lasts three frames
    foodGiven = 1'b1; pillsGiven = 1'b1;
    step();
    foodGiven = 1'b0; pillsGiven = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tick();
      serve("t4_bg", L_BG, 2, 1);
      serve("t4_pet", L_PET, 2, 1);
      serve("t4_item", L_PILLS, 2, 2);
      finish_frame("t4", 2);
    end
    tick();
    serve("t4_bg4", L_BG, 2, 1);
    serve("t4_pet4", L_PET, 2, 1);
    finish_frame("t4_last", 4);

    // T5: layer watchdog
    check("t5_tmo0", {31'd0, timeout_err}, 32'd0);
    tick();
    n = 0;
    while (draws == 15'd0 && n < 64) begin step(); n++; end
    check("t5_bg", {17'd0, draws}, {17'd0, L_BG});
    n = 0;
    while (draws == L_BG && n < 40) begin step(); n++; end
    check("t5_len", n, 16);
    check("t5_tmo", {31'd0, timeout_err}, 32'd1);
    serve("t5_pet", L_PET, 2, 1);
    finish_frame("t5", 4);

    // T6: overrun saturation, then end and start screens
    frame_tick = 1'b1;
    repeat (300) step();
    frame_tick = 1'b0;
    check("t6_ovr", {24'd0, overrun_cnt}, 32'd255);
    n = 0;
    while (frame_busy && n < 200) begin step(); n++; end
    check("t6_idle_wait", {31'd0, frame_busy}, 32'd0);
    deceased = 1'b1;
    tick();
    serve("t6_end", L_END, 2, 1);
    finish_frame("t6_end", 1);
    start_btn = 1'b1;
    tick();
    serve("t6_start", L_START, 2, 1);
    finish_frame("t6_start", 1);
    deceased = 1'b0;

    // Reset mid-layer clears every output on the next edge
    tick();
    n = 0;
    while (draws == 15'd0 && n < 64) begin step(); n++; end
    check("rm_start", {17'd0, draws}, {17'd0, L_START});
    resetn = 1'b0;
    step();
    check("rm_draws", {17'd0, draws}, 32'd0);
    check("rm_busy", {31'd0, frame_busy}, 32'd0);
    check("rm_ovr", {24'd0, overrun_cnt}, 32'd0);
    check("rm_tmo", {31'd0, timeout_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
